hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers after decode and
// produces operand forwarding selects plus a load-use stall request.
// Entry 0 is EX, entry DEPTH-1 is WB. The youngest matching entry wins.
// Optional feature macro: HAZARD_STATS_EN builds a saturating stall counter
// on StallCount; without it StallCount is tied to zero.
module hazard_scoreboard #(
    parameter int DEPTH      = 3,
    parameter int AW         = 5,
    parameter int LOAD_STAGE = 2
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         IssueValid,
    input  logic [AW-1:0]                IssueDest,
    input  logic                         IssueRegWrite,
    input  logic                         IssueIsLoad,
    input  logic [AW-1:0]                SrcA,
    input  logic [AW-1:0]                SrcB,
    input  logic                         SrcAUsed,
    input  logic                         SrcBUsed,
    input  logic                         Flush,
    input  logic                         Hold,
    output logic                         Stall,
    output logic [$clog2(DEPTH+1)-1:0]   FwdSelA,
    output logic [$clog2(DEPTH+1)-1:0]   FwdSelB,
    output logic [31:0]                  StallCount
);

    localparam int SW = $clog2(DEPTH + 1);

    // Per-stage scoreboard entries {Valid, Dest, RegWrite, IsLoad}.
    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] dest_q, dest_d;
    logic [DEPTH-1:0]         regwr_q, regwr_d;
    logic [DEPTH-1:0]         isload_q, isload_d;

    logic [SW-1:0] fwd_a, fwd_b;
    logic          haz_a, haz_b;
    logic          stall;
    logic          issue_take;

    // Source lookup: scan oldest to youngest so the youngest match is the
    // last assignment; a younger non-load match therefore masks an older load.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        haz_a = 1'b0;
        haz_b = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (SrcAUsed && (SrcA != '0) && valid_q[i] && regwr_q[i] &&
                (dest_q[i] == SrcA)) begin
                fwd_a = SW'(i + 1);
                haz_a = isload_q[i] && (i < LOAD_STAGE);
            end
            if (SrcBUsed && (SrcB != '0) && valid_q[i] && regwr_q[i] &&
                (dest_q[i] == SrcB)) begin
                fwd_b = SW'(i + 1);
                haz_b = isload_q[i] && (i < LOAD_STAGE);
            end
        end
        stall = IssueValid && (haz_a || haz_b);
    end

    assign Stall   = stall;
    assign FwdSelA = fwd_a;
    assign FwdSelB = fwd_b;

    // Next-state: shift the pipeline unless held; entry 0 takes the issuing
    // instruction, or a bubble when stalled, flushed or nothing is issuing.
    always_comb begin
        valid_d    = valid_q;
        dest_d     = dest_q;
        regwr_d    = regwr_q;
        isload_d   = isload_q;
        issue_take = IssueValid && !stall && !Flush;
        if (!Hold) begin
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i]  = valid_q[i-1];
                dest_d[i]   = dest_q[i-1];
                regwr_d[i]  = regwr_q[i-1];
                isload_d[i] = isload_q[i-1];
            end
            valid_d[0]  = issue_take;
            dest_d[0]   = issue_take ? IssueDest : '0;
            regwr_d[0]  = issue_take && IssueRegWrite;
            isload_d[0] = issue_take && IssueIsLoad;
        end
    end

    // Scoreboard register; reset clears every entry to a bubble at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            valid_q  <= '0;
            dest_q   <= '0;
            regwr_q  <= '0;
            isload_q <= '0;
        end else begin
            valid_q  <= valid_d;
            dest_q   <= dest_d;
            regwr_q  <= regwr_d;
            isload_q <= isload_d;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;

    // Stall statistics: count cycles that actually stall, saturating.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && !Hold && (stall_count_q != 32'hFFFF_FFFF)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign StallCount = stall_count_q;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard (DEPTH=3, AW=5,
// LOAD_STAGE=2). Each table row is applied after a falling edge and the
// combinational outputs are compared before the next rising edge.
module tb_hazard_scoreboard;

    logic        Clock;
    logic        Reset;
    logic        IssueValid;
    logic [4:0]  IssueDest;
    logic        IssueRegWrite;
    logic        IssueIsLoad;
    logic [4:0]  SrcA;
    logic [4:0]  SrcB;
    logic        SrcAUsed;
    logic        SrcBUsed;
    logic        Flush;
    logic        Hold;
    logic        Stall;
    logic [1:0]  FwdSelA;
    logic [1:0]  FwdSelB;
    logic [31:0] StallCount;

    hazard_scoreboard #(
        .DEPTH      (3),
        .AW         (5),
        .LOAD_STAGE (2)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .IssueValid    (IssueValid),
        .IssueDest     (IssueDest),
        .IssueRegWrite (IssueRegWrite),
        .IssueIsLoad   (IssueIsLoad),
        .SrcA          (SrcA),
        .SrcB          (SrcB),
        .SrcAUsed      (SrcAUsed),
        .SrcBUsed      (SrcBUsed),
        .Flush         (Flush),
        .Hold          (Hold),
        .Stall         (Stall),
        .FwdSelA       (FwdSelA),
        .FwdSelB       (FwdSelB),
        .StallCount    (StallCount)
    );

    // Clock generation.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic        iv;
        logic [4:0]  dest;
        logic        rw;
        logic        ld;
        logic [4:0]  sa;
        logic        ua;
        logic [4:0]  sb;
        logic        ub;
        logic        flush;
        logic        hold;
        logic        exp_stall;
        logic [1:0]  exp_fa;
        logic [1:0]  exp_fb;
        logic [31:0] exp_cnt;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs[NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(int iv, int dest, int rw, int ld,
                                int sa, int ua, int sb, int ub,
                                int flush, int hold,
                                int stall, int fa, int fb, int cnt);
        vec_t v;
        v.iv        = 1'(iv);
        v.dest      = 5'(dest);
        v.rw        = 1'(rw);
        v.ld        = 1'(ld);
        v.sa        = 5'(sa);
        v.ua        = 1'(ua);
        v.sb        = 5'(sb);
        v.ub        = 1'(ub);
        v.flush     = 1'(flush);
        v.hold      = 1'(hold);
        v.exp_stall = 1'(stall);
        v.exp_fa    = 2'(fa);
        v.exp_fb    = 2'(fb);
        v.exp_cnt   = 32'(cnt);
        return v;
    endfunction

    // Expected StallCount: the counter only exists with the stats feature.
    function automatic logic [31:0] exp_count(logic [31:0] c);
`ifdef HAZARD_STATS_EN
        return c;
`else
        return 32'd0 & c;
`endif
    endfunction

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        IssueValid    = v.iv;
        IssueDest     = v.dest;
        IssueRegWrite = v.rw;
        IssueIsLoad   = v.ld;
        SrcA          = v.sa;
        SrcAUsed      = v.ua;
        SrcB          = v.sb;
        SrcBUsed      = v.ub;
        Flush         = v.flush;
        Hold          = v.hold;
    endtask

    task automatic check_outputs(input string tag, input int idx,
                                 input logic stall, input logic [1:0] fa,
                                 input logic [1:0] fb, input logic [31:0] cnt);
        check({tag, "_stall"}, idx, 32'(Stall), 32'(stall));
        check({tag, "_fwda"},  idx, 32'(FwdSelA), 32'(fa));
        check({tag, "_fwdb"},  idx, 32'(FwdSelB), 32'(fb));
        check({tag, "_cnt"},   idx, StallCount, exp_count(cnt));
    endtask

    initial begin
        // Columns: iv dest rw ld | sa ua sb ub | flush hold | stall fa fb cnt
        vecs[0]  = mk(0, 0, 0,0,  0,0,  0,0, 0,0, 0,0,0,0);
        // add $3, then read $3 as it ages through EX, MEM, WB and retires
        vecs[1]  = mk(1, 3, 1,0,  0,0,  0,0, 0,0, 0,0,0,0);
        vecs[2]  = mk(1, 9, 0,0,  3,1,  0,0, 0,0, 0,1,0,0);
        vecs[3]  = mk(0, 0, 0,0,  3,1,  0,0, 0,0, 0,2,0,0);
        vecs[4]  = mk(0, 0, 0,0,  3,1,  0,0, 0,0, 0,3,0,0);
        vecs[5]  = mk(0, 0, 0,0,  3,1,  0,0, 0,0, 0,0,0,0);
        // lw $5, independent add $8, consumer of $5 stalls once then forwards from stage 2
        vecs[6]  = mk(1, 5, 1,1,  0,0,  0,0, 0,0, 0,0,0,0);
        vecs[7]  = mk(1, 8, 1,0,  0,0,  0,0, 0,0, 0,0,0,0);
        vecs[8]  = mk(1, 6, 1,0,  0,0,  5,1, 0,0, 1,0,2,0);
        vecs[9]  = mk(1, 6, 1,0,  0,0,  5,1, 0,0, 0,0,3,1);
        // lw $4 then add $4: younger add masks the load; srcB=$6 from WB
        vecs[10] = mk(1, 4, 1,1,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[11] = mk(1, 4, 1,0,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[12] = mk(1,10, 1,0,  4,1,  6,1, 0,0, 0,1,3,1);
        // dest $0 never matches; unused source never matches
        vecs[13] = mk(1, 0, 1,0,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[14] = mk(1,11, 1,0,  0,1, 10,0, 0,0, 0,0,0,1);
        vecs[15] = mk(1,12, 1,1,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[16] = mk(1,13, 1,0, 12,0, 11,1, 0,0, 0,0,2,1);
        // RegWrite=0 entry does not match; load in WB forwards without stall
        vecs[17] = mk(1,14, 0,0,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[18] = mk(0, 0, 0,0, 14,1, 12,1, 0,0, 0,0,3,1);
        // flushed add $7 leaves a bubble
        vecs[19] = mk(1, 7, 1,0,  0,0,  0,0, 1,0, 0,0,0,1);
        vecs[20] = mk(0, 0, 0,0,  7,1,  0,0, 0,0, 0,0,0,1);
        // back-to-back load-use with a 3-cycle hold in the middle of the stall
        vecs[21] = mk(1, 9, 1,1,  0,0,  0,0, 0,0, 0,0,0,1);
        vecs[22] = mk(1,15, 1,0,  9,1,  0,0, 0,0, 1,1,0,1);
        vecs[23] = mk(1,15, 1,0,  9,1,  0,0, 0,1, 1,2,0,2);
        vecs[24] = mk(1,15, 1,0,  9,1,  0,0, 0,1, 1,2,0,2);
        vecs[25] = mk(1,15, 1,0,  9,1,  0,0, 0,1, 1,2,0,2);
        vecs[26] = mk(1,15, 1,0,  9,1,  0,0, 0,0, 1,2,0,2);
        vecs[27] = mk(1,15, 1,0,  9,1,  0,0, 0,0, 0,3,0,3);
        // hold with flush and an issue: nothing moves, nothing is loaded
        vecs[28] = mk(1,16, 1,0, 15,1,  0,0, 1,1, 0,1,0,3);
        vecs[29] = mk(0, 0, 0,0, 15,1, 16,1, 0,0, 0,1,0,3);
        vecs[30] = mk(0, 0, 0,0, 15,1,  0,0, 0,0, 0,2,0,3);

        // Reset phase: outputs must be quiet even with a busy decode stage.
        Reset = 1'b0;
        drive(mk(1, 3, 1,1, 3,1, 3,1, 0,0, 0,0,0,0));
        repeat (2) @(negedge Clock);
        #1;
        check_outputs("reset", 0, 1'b0, 2'd0, 2'd0, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            if (i > 0) @(negedge Clock);
            drive(vecs[i]);
            #1;
            check_outputs("vec", i, vecs[i].exp_stall, vecs[i].exp_fa,
                          vecs[i].exp_fb, vecs[i].exp_cnt);
        end

        // Reset asserted mid-stall, between clock edges.
        @(negedge Clock);
        drive(mk(1,20, 1,1,  0,0, 0,0, 0,0, 0,0,0,0));
        @(negedge Clock);
        drive(mk(1,21, 1,0, 20,1, 0,0, 0,0, 0,0,0,0));
        #1;
        check_outputs("prestall", 0, 1'b1, 2'd1, 2'd0, 32'd3);
        #2;
        Reset = 1'b0;
        #1;
        check_outputs("async_rst", 0, 1'b0, 2'd0, 2'd0, 32'd0);
        @(negedge Clock);
        #1;
        check_outputs("rst_hold", 0, 1'b0, 2'd0, 2'd0, 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        // First edge after release is a normal issue of add $3.
        drive(mk(1, 3, 1,0, 20,1, 0,0, 0,0, 0,0,0,0));
        #1;
        check_outputs("post_rst", 0, 1'b0, 2'd0, 2'd0, 32'd0);
        @(negedge Clock);
        drive(mk(0, 0, 0,0,  3,1, 0,0, 0,0, 0,0,0,0));
        #1;
        check_outputs("post_rst", 1, 1'b0, 2'd1, 2'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
